obi_instr_arbiter: RTL and testbench
====================================

Name: obi_instr_arbiter

Overview:
- Two-requester arbiter sharing one OBI instruction-memory port between the prefetch buffer (m0) and a secondary fetcher such as a debug/program loader (m1).
- Arbitrates address phases round-robin or with fixed priority.
- Holds OBI address-phase stability until grant.
- Tracks up to DEPTH outstanding transactions in an in-order ID FIFO, so each in-order response is routed back to the master that issued it.

Parameters:
DEPTH, 2, max outstanding granted-but-unanswered transactions (>=1)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, read-data width
RR_EN, 1, 1 = round-robin; 0 = fixed priority, m0 wins

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
m0_req_i  in  1  m0 address-phase request
m0_addr_i  in  ADDR_WIDTH  m0 address
m0_gnt_o  out  1  m0 grant
m0_rvalid_o  out  1  m0 response valid
m0_rdata_o  out  DATA_WIDTH  m0 read data
m0_err_o  out  1  m0 response error
m1_req_i, m1_addr_i, m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o  (same directions/widths as m0)
s_req_o  out  1  request to instruction memory
s_addr_o  out  ADDR_WIDTH  address to memory
s_gnt_i  in  1  memory grant
s_rvalid_i  in  1  memory response valid
s_rdata_i  in  DATA_WIDTH  memory read data
s_err_i  in  1  memory response error
outstanding_o  out  $clog2(DEPTH+1)  current outstanding count
busy_o  out  1  request pending or outstanding
protocol_err_o  out  1  sticky protocol-violation flag

Behaviour:
- Reset (async, rst_n=0):
  - FIFO empty, count 0, lock cleared, last_winner=m1 (so m0 wins first tie under RR), protocol_err_o=0.
  - All gnt/rvalid/err outputs 0; s_req_o=0.
- Selection (combinational):
  - If locked: sel = locked master.
  - Else if only one request: that master.
  - Else if both: RR_EN=1 -> master != last_winner; RR_EN=0 -> m0.
- Address phase:
  - s_req_o = req of sel && !full.
  - s_addr_o = addr of sel; it is a don't-care when s_req_o=0.
  - full = (count==DEPTH). Full blocks new requests even if a pop occurs the same cycle; there is no pass-through.
- Grant:
  - mX_gnt_o = s_gnt_i && s_req_o && sel==X. Same-cycle combinational path from s_gnt_i.
  - On grant: push sel into FIFO and set last_winner=sel.
- Lock (OBI stability):
  - s_req_o=1 && s_gnt_i=0 -> register lock on sel; other master's request is ignored until grant.
  - Grant clears lock.
  - Locked master drops req before grant -> lock cleared and protocol_err_o set; no push.
- Response phase:
  - s_rvalid_i with FIFO non-empty -> mX_rvalid_o=1 for X=FIFO head (combinational), mX_err_o=s_err_i; pop in the same cycle.
  - m0_rdata_o and m1_rdata_o = s_rdata_i (broadcast); rvalid qualifies the data.
  - Non-head master sees rvalid=0 and err=0.
  - s_rvalid_i with FIFO empty -> response dropped, no mX_rvalid_o, protocol_err_o set.
- Responses are strictly in order; a response is never accepted in the same cycle as its own grant. A same-cycle push (new grant) plus pop (older response) is legal; count is unchanged.
- Count: +1 on push only, -1 on pop only, wraps never; push when full is impossible by construction.
- Status outputs:
  - busy_o = (count!=0) || s_req_o.
  - outstanding_o = count, registered.
  - protocol_err_o is sticky until reset.
- Reset mid-operation: all tracking is discarded. Late responses for pre-reset transactions arrive with the FIFO empty and raise protocol_err_o (documented, intended).

Test Plan:
- m0 single fetch: m0_req=1, addr=0x0000_0080, s_gnt=1 in cycle 0, s_rvalid=1 rdata=0x0051_0513 in cycle 2 -> m0_gnt=1 cycle 0, m0_rvalid=1 cycle 2 with that rdata; m1_rvalid=0; outstanding 0->1->1->0.
- RR contention, RR_EN=1, both req continuously, s_gnt=1 every cycle, rvalid one cycle after each grant -> grants m0,m1,m0,m1; responses routed in grant order; count never exceeds 1.
- Wait-state lock: m1 req addr=0x1000, s_gnt=0 for 3 cycles, m0 asserts req in cycle 1 -> s_addr stays 0x1000 and sel=m1 until grant cycle 3; m0 granted next.
- Full stall, DEPTH=2: two grants with no rvalid -> s_req_o=0, outstanding_o=2 while m0_req=1; first rvalid pops -> s_req_o=1 the following cycle.
- Error/violation: rvalid with s_err=1 -> head master err=1. Spurious s_rvalid with count 0 -> no mX_rvalid, protocol_err_o=1 held until rst_n=0.
- Async reset with 2 outstanding: rst_n low mid-cycle -> outputs 0 immediately, outstanding_o=0; a later s_rvalid sets protocol_err_o.

Source files
------------

// File: rtl/obi_instr_arbiter.sv
// Two-master OBI instruction-port arbiter: round-robin or fixed-priority address
// arbitration, address-phase locking until grant, in-order response routing via an ID FIFO.
module obi_instr_arbiter #(
    parameter int DEPTH      = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter bit RR_EN      = 1'b1,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_req_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    output logic                  m0_gnt_o,
    output logic                  m0_rvalid_o,
    output logic [DATA_WIDTH-1:0] m0_rdata_o,
    output logic                  m0_err_o,
    input  logic                  m1_req_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    output logic                  m1_gnt_o,
    output logic                  m1_rvalid_o,
    output logic [DATA_WIDTH-1:0] m1_rdata_o,
    output logic                  m1_err_o,
    output logic                  s_req_o,
    output logic [ADDR_WIDTH-1:0] s_addr_o,
    input  logic                  s_gnt_i,
    input  logic                  s_rvalid_i,
    input  logic [DATA_WIDTH-1:0] s_rdata_i,
    input  logic                  s_err_i,
    output logic [CW-1:0]         outstanding_o,
    output logic                  busy_o,
    output logic                  protocol_err_o
);

    // Handshake: an address phase completes when s_req_o && s_gnt_i; once s_req_o
    // rises the selected master and address stay fixed until that grant.
    logic [DEPTH-1:0] id_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    wr_idx;
    logic             lock_q;
    logic             lock_id_q;
    logic             last_winner_q;
    logic             perr_q;
    logic             sel;
    logic             sel_req;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             head;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = id_q[0];

    always_comb begin
        sel = 1'b0;
        if (lock_q) begin
            sel = lock_id_q;
        end else if (m0_req_i && !m1_req_i) begin
            sel = 1'b0;
        end else if (m1_req_i && !m0_req_i) begin
            sel = 1'b1;
        end else if (m0_req_i && m1_req_i) begin
            sel = RR_EN ? ~last_winner_q : 1'b0;
        end
    end

    assign sel_req  = sel ? m1_req_i : m0_req_i;
    // Held low while in reset so the memory never sees a request from a discarded state.
    assign s_req_o  = rst_n && sel_req && !full;
    assign s_addr_o = sel ? m1_addr_i : m0_addr_i;

    assign push     = s_req_o && s_gnt_i;
    assign m0_gnt_o = push && !sel;
    assign m1_gnt_o = push && sel;

    // Response for the FIFO head only; an older response may pop while a new grant pushes.
    assign pop         = s_rvalid_i && !empty;
    assign m0_rvalid_o = pop && !head;
    assign m1_rvalid_o = pop && head;
    assign m0_err_o    = m0_rvalid_o && s_err_i;
    assign m1_err_o    = m1_rvalid_o && s_err_i;
    assign m0_rdata_o  = s_rdata_i;
    assign m1_rdata_o  = s_rdata_i;

    assign wr_idx = count_q - CW'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q          <= '0;
            count_q       <= '0;
            lock_q        <= 1'b0;
            lock_id_q     <= 1'b0;
            last_winner_q <= 1'b1;
            perr_q        <= 1'b0;
        end else begin
            if (pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    id_q[i] <= id_q[i+1];
                end
            end
            if (push) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (CW'(i) == wr_idx) begin
                        id_q[i] <= sel;
                    end
                end
            end

            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end

            if (s_req_o && !s_gnt_i) begin
                lock_q    <= 1'b1;
                lock_id_q <= sel;
            end else if (push) begin
                lock_q        <= 1'b0;
                last_winner_q <= sel;
            end else if (lock_q && !sel_req) begin
                // Master withdrew an address phase that the memory had not yet granted.
                lock_q <= 1'b0;
                perr_q <= 1'b1;
            end

            if (s_rvalid_i && empty) begin
                perr_q <= 1'b1;
            end
        end
    end

    assign outstanding_o  = count_q;
    assign busy_o         = !empty || s_req_o;
    assign protocol_err_o = perr_q;

endmodule

// File: tb/tb_obi_instr_arbiter.sv
// Self-checking bench for obi_instr_arbiter (DEPTH=2, round-robin), with a response
// scoreboard fed when responses are driven and drained when the DUT routes them.
module tb_obi_instr_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int W  = DW + 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_req_i, m1_req_i;
    logic [AW-1:0] m0_addr_i, m1_addr_i;
    logic          m0_gnt_o, m0_rvalid_o, m0_err_o;
    logic          m1_gnt_o, m1_rvalid_o, m1_err_o;
    logic [DW-1:0] m0_rdata_o, m1_rdata_o;
    logic          s_req_o;
    logic [AW-1:0] s_addr_o;
    logic          s_gnt_i, s_rvalid_i, s_err_i;
    logic [DW-1:0] s_rdata_i;
    logic [1:0]    outstanding_o;
    logic          busy_o, protocol_err_o;

    int vectors     = 0;
    int miscompares = 0;
    logic [W-1:0] exp_q[$];

    obi_instr_arbiter #(.DEPTH(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_gnt_o(m0_gnt_o),
        .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
        .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_gnt_o(m1_gnt_o),
        .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
        .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_gnt_i(s_gnt_i),
        .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i), .s_err_i(s_err_i),
        .outstanding_o(outstanding_o), .busy_o(busy_o), .protocol_err_o(protocol_err_o)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic apply_reset();
        rst_n = 1'b0;
        m0_req_i = 0; m1_req_i = 0; m0_addr_i = '0; m1_addr_i = '0;
        s_gnt_i = 0; s_rvalid_i = 0; s_rdata_i = '0; s_err_i = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Driver: inputs change #1 after the rising edge, outputs are checked at the falling edge.
    task automatic drive(input logic r0, input logic [AW-1:0] a0, input logic r1,
                         input logic [AW-1:0] a1, input logic g, input logic rv,
                         input logic [DW-1:0] rd, input logic e);
        m0_req_i = r0; m0_addr_i = a0; m1_req_i = r1; m1_addr_i = a1;
        s_gnt_i = g; s_rvalid_i = rv; s_rdata_i = rd; s_err_i = e;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rsp(input logic id, input logic [DW-1:0] d, input logic e);
        if (id) exp_q.push_back({2'b10, e, 1'b0, d});
        else    exp_q.push_back({2'b01, 1'b0, e, d});
    endtask

    // Scoreboard: every routed response must match the oldest expected one.
    always @(negedge clk) begin
        logic [W-1:0] act, exp_item;
        if (m0_rvalid_o || m1_rvalid_o) begin
            vectors++;
            act = {m1_rvalid_o, m0_rvalid_o, m1_err_o, m0_err_o,
                   (m1_rvalid_o ? m1_rdata_o : m0_rdata_o)};
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL rsp_unexpected: got %h, none expected", act);
            end else begin
                exp_item = exp_q.pop_front();
                if (act !== exp_item) begin
                    miscompares++;
                    $display("FAIL rsp_route: got %h, expected %h", act, exp_item);
                end
            end
        end
    end

    task automatic check_drained(input string name);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_rsp_missing: %0d pending, expected 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1, 32'h40, 1, 32'h44, 1, 0, '0, 0);
        @(negedge clk);
        vectors++;
        if ({s_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b, expected 0",
                     {s_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o});
        end
        vectors++;
        if ({outstanding_o, busy_o, protocol_err_o} !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_status: got %b, expected 0000", {outstanding_o, busy_o, protocol_err_o});
        end
        apply_reset();
    endtask

    task automatic test_single_fetch();
        logic [1:0] exp_cnt [4] = '{2'd0, 2'd1, 2'd1, 2'd0};
        apply_reset();
        for (int c = 0; c < 4; c++) begin
            case (c)
                0: drive(1, 32'h0000_0080, 0, '0, 1, 0, '0, 0);
                2: begin
                    drive(0, '0, 0, '0, 0, 1, 32'h0051_0513, 0);
                    expect_rsp(1'b0, 32'h0051_0513, 1'b0);
                end
                default: drive(0, '0, 0, '0, 0, 0, '0, 0);
            endcase
            @(negedge clk);
            if (c == 0) begin
                vectors++;
                if ({s_req_o, m0_gnt_o, m1_gnt_o, s_addr_o} !== {3'b110, 32'h0000_0080}) begin
                    miscompares++;
                    $display("FAIL single_grant: got %b/%h, expected 110/00000080",
                             {s_req_o, m0_gnt_o, m1_gnt_o}, s_addr_o);
                end
            end
            vectors++;
            if (outstanding_o !== exp_cnt[c]) begin
                miscompares++;
                $display("FAIL single_count c%0d: got %0d, expected %0d", c, outstanding_o, exp_cnt[c]);
            end
            next_cycle();
        end
        check_drained("single");
    endtask

    task automatic test_rr_contention();
        logic [DW-1:0] d;
        logic prev;
        apply_reset();
        prev = 1'b0;
        for (int k = 0; k < 5; k++) begin
            d = $urandom;
            if (k < 4) drive(1, 32'h100 + k*4, 1, 32'h200 + k*4, 1, (k > 0), d, 0);
            else       drive(0, '0, 0, '0, 0, 1, d, 0);
            if (k > 0) expect_rsp(prev, d, 1'b0);
            @(negedge clk);
            if (k < 4) begin
                vectors++;
                if ({m1_gnt_o, m0_gnt_o} !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                    miscompares++;
                    $display("FAIL rr_grant k%0d: got %b, expected %b", k, {m1_gnt_o, m0_gnt_o},
                             (k % 2 == 0) ? 2'b01 : 2'b10);
                end
            end
            vectors++;
            if (outstanding_o !== ((k == 0) ? 2'd0 : 2'd1)) begin
                miscompares++;
                $display("FAIL rr_count k%0d: got %0d, expected %0d", k, outstanding_o, (k == 0) ? 0 : 1);
            end
            prev = (k % 2 == 1);
            next_cycle();
        end
        check_drained("rr");
    endtask

    task automatic test_lock();
        logic m0r;
        apply_reset();
        for (int c = 0; c < 5; c++) begin
            m0r = (c >= 1);
            drive(m0r, 32'h2000, (c < 4), 32'h1000, (c >= 3), 0, '0, 0);
            @(negedge clk);
            vectors++;
            if (c < 4) begin
                if ({s_req_o, s_addr_o, m1_gnt_o, m0_gnt_o} !== {1'b1, 32'h1000, (c == 3), 1'b0}) begin
                    miscompares++;
                    $display("FAIL lock_hold c%0d: got req=%b addr=%h gnt=%b, expected 1/00001000/%b0",
                             c, s_req_o, s_addr_o, {m1_gnt_o, m0_gnt_o}, (c == 3));
                end
            end else if ({s_addr_o, m1_gnt_o, m0_gnt_o} !== {32'h2000, 2'b01}) begin
                miscompares++;
                $display("FAIL lock_next: got addr=%h gnt=%b, expected 00002000/01",
                         s_addr_o, {m1_gnt_o, m0_gnt_o});
            end
            next_cycle();
        end
        drive(0, '0, 0, '0, 0, 1, 32'hAAAA_0001, 0);
        expect_rsp(1'b1, 32'hAAAA_0001, 1'b0);
        next_cycle();
        drive(0, '0, 0, '0, 0, 1, 32'hBBBB_0002, 0);
        expect_rsp(1'b0, 32'hBBBB_0002, 1'b0);
        next_cycle();
        drive(0, '0, 0, '0, 0, 0, '0, 0);
        @(negedge clk);
        vectors++;
        if (outstanding_o !== 2'd0) begin
            miscompares++;
            $display("FAIL lock_drain_count: got %0d, expected 0", outstanding_o);
        end
        next_cycle();
        check_drained("lock");
    endtask

    task automatic test_full_stall();
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            drive((c < 5), 32'h300 + c*4, 0, '0, 1, (c == 3 || c >= 5), 32'hF00 + c, 0);
            if (c == 3 || c == 5 || c == 6) expect_rsp(1'b0, 32'hF00 + c, 1'b0);
            @(negedge clk);
            if (c == 2 || c == 3) begin
                vectors++;
                if ({s_req_o, m0_gnt_o, outstanding_o, busy_o} !== {2'b00, 2'd2, 1'b1}) begin
                    miscompares++;
                    $display("FAIL full_stall c%0d: got req=%b gnt=%b cnt=%0d busy=%b, expected 0/0/2/1",
                             c, s_req_o, m0_gnt_o, outstanding_o, busy_o);
                end
            end
            if (c == 4) begin
                vectors++;
                if ({s_req_o, m0_gnt_o, outstanding_o} !== {2'b11, 2'd1}) begin
                    miscompares++;
                    $display("FAIL full_resume: got req=%b gnt=%b cnt=%0d, expected 1/1/1",
                             s_req_o, m0_gnt_o, outstanding_o);
                end
            end
            if (c == 7) begin
                vectors++;
                if (outstanding_o !== 2'd0) begin
                    miscompares++;
                    $display("FAIL full_drain: got %0d, expected 0", outstanding_o);
                end
            end
            next_cycle();
        end
        check_drained("full");
    endtask

    task automatic test_error_violation();
        apply_reset();
        drive(0, '0, 1, 32'h500, 1, 0, '0, 0);
        next_cycle();
        drive(0, '0, 0, '0, 0, 1, 32'hDEAD_BEEF, 1);
        expect_rsp(1'b1, 32'hDEAD_BEEF, 1'b1);
        @(negedge clk);
        vectors++;
        if (protocol_err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL err_rsp_perr: got %b, expected 0", protocol_err_o);
        end
        next_cycle();
        drive(0, '0, 0, '0, 0, 1, 32'h1234_5678, 0);
        @(negedge clk);
        vectors++;
        if ({m1_rvalid_o, m0_rvalid_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL spurious_rvalid: got %b, expected 00", {m1_rvalid_o, m0_rvalid_o});
        end
        next_cycle();
        drive(0, '0, 0, '0, 0, 0, '0, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (protocol_err_o !== 1'b1) begin
                miscompares++;
                $display("FAIL spurious_perr_sticky c%0d: got %b, expected 1", c, protocol_err_o);
            end
            next_cycle();
        end
        check_drained("err");
    endtask

    task automatic test_lock_drop();
        apply_reset();
        drive(1, 32'h600, 0, '0, 0, 0, '0, 0);
        next_cycle();
        drive(0, '0, 0, '0, 0, 0, '0, 0);
        next_cycle();
        @(negedge clk);
        vectors++;
        if ({protocol_err_o, outstanding_o, s_req_o} !== {1'b1, 2'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL lock_drop: got perr=%b cnt=%0d req=%b, expected 1/0/0",
                     protocol_err_o, outstanding_o, s_req_o);
        end
        next_cycle();
    endtask

    task automatic test_async_reset();
        apply_reset();
        drive(1, 32'h700, 0, '0, 1, 0, '0, 0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        vectors++;
        if ({outstanding_o, s_req_o} !== {2'd2, 1'b0}) begin
            miscompares++;
            $display("FAIL areset_pre: got cnt=%0d req=%b, expected 2/0", outstanding_o, s_req_o);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({s_req_o, m0_gnt_o, m1_gnt_o, outstanding_o, busy_o, protocol_err_o} !== 7'b0) begin
            miscompares++;
            $display("FAIL areset_now: got %b, expected 0",
                     {s_req_o, m0_gnt_o, m1_gnt_o, outstanding_o, busy_o, protocol_err_o});
        end
        drive(0, '0, 0, '0, 0, 0, '0, 0);
        next_cycle();
        rst_n = 1'b1;
        drive(0, '0, 0, '0, 0, 1, 32'hCAFE_0000, 0);
        @(negedge clk);
        vectors++;
        if ({m1_rvalid_o, m0_rvalid_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL areset_late_rvalid: got %b, expected 00", {m1_rvalid_o, m0_rvalid_o});
        end
        next_cycle();
        drive(0, '0, 0, '0, 0, 0, '0, 0);
        @(negedge clk);
        vectors++;
        if (protocol_err_o !== 1'b1) begin
            miscompares++;
            $display("FAIL areset_late_perr: got %b, expected 1", protocol_err_o);
        end
        next_cycle();
        check_drained("areset");
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_rr_contention();
        test_lock();
        test_full_stall();
        test_error_violation();
        test_lock_drop();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
